// File: rtl/pc_reg.sv
// pc_reg: program-counter register for the rv32i datapath.
// Holds the fetch address, loads pcNext on enabled rising edges, and
// provides pc+4 and a misalignment flag.
// Optional macro PC_HISTORY_EN adds a circular history buffer of previous
// pc values with the histSel/histPc read port.
module pc_reg #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               HIST_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [WIDTH-1:0]              pcNext,
`ifdef PC_HISTORY_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] histSel,
  output logic [WIDTH-1:0]              histPc,
`endif
  output logic [WIDTH-1:0]              pc,
  output logic [WIDTH-1:0]              pcPlus4,
  output logic                          misaligned
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next pc: load pcNext when enabled, otherwise hold (stall).
  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = pcNext;
    end
  end

  // pc register; reset forces the reset vector immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc         = pc_q;
  // Wraps modulo 2^WIDTH; no carry is reported.
  assign pcPlus4    = pc_q + WIDTH'(4);
  // Informational only; the control unit raises the trap.
  assign misaligned = |pc_q[1:0];

`ifdef PC_HISTORY_EN
  localparam int HAW = $clog2(HIST_DEPTH);

  logic [WIDTH-1:0] hist_q [HIST_DEPTH];
  logic [WIDTH-1:0] hist_d [HIST_DEPTH];
  logic [HAW-1:0]   wr_ptr_q;
  logic [HAW-1:0]   wr_ptr_d;
  logic [HAW-1:0]   rd_idx;

  // Push the outgoing pc into the ring on every enabled update.
  always_comb begin
    hist_d   = hist_q;
    wr_ptr_d = wr_ptr_q;
    if (en) begin
      hist_d[wr_ptr_q] = pc_q;
      wr_ptr_d         = wr_ptr_q + HAW'(1);
    end
  end

  // History storage; reset fills every entry with the reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= RESET_VECTOR;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      hist_q   <= hist_d;
    end
  end

  // histSel=0 is the most recently pushed entry, counting backwards.
  always_comb begin
    rd_idx = wr_ptr_q - HAW'(1) - histSel;
    histPc = hist_q[rd_idx];
  end
`endif

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed vector table, hand-written
// reset/hold sequences, and randomized traffic against a reference model.
module tb_pc_reg;

  localparam int WIDTH = 16;
  localparam int HD    = 4;
  localparam int HAW   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pcPlus4;
  logic             misaligned;
`ifdef PC_HISTORY_EN
  logic [HAW-1:0]   histSel;
  logic [WIDTH-1:0] histPc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pc_reg #(.WIDTH(WIDTH), .RESET_VECTOR(16'h0000), .HIST_DEPTH(HD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pcNext     (pcNext),
`ifdef PC_HISTORY_EN
    .histSel    (histSel),
    .histPc     (histPc),
`endif
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [WIDTH-1:0] exp_pc);
    logic [WIDTH-1:0] exp_p4;
    exp_p4 = WIDTH'((32'(exp_pc) + 32'd4) % 32'h10000);
    chk({name, ".pc"}, 32'(pc), 32'(exp_pc));
    chk({name, ".pcPlus4"}, 32'(pcPlus4), 32'(exp_p4));
    chk({name, ".misaligned"}, 32'(misaligned), 32'((exp_pc % 4) != 0));
  endtask

  typedef struct {
    logic             en;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] exp_pc;
    logic [WIDTH-1:0] exp_p4;
    logic             exp_mis;
  } vec_t;

  vec_t vecs [12];

  // Reference model state.
  logic [WIDTH-1:0] m_pc;
  logic [WIDTH-1:0] hq [$];

  task automatic model_reset();
    m_pc = '0;
    hq.delete();
    for (int i = 0; i < HD; i++) hq.push_back('0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h0004, 16'h0004, 16'h0008, 1'b0};
    vecs[1]  = '{1'b1, 16'h0008, 16'h0008, 16'h000C, 1'b0};
    vecs[2]  = '{1'b0, 16'h0020, 16'h0008, 16'h000C, 1'b0};
    vecs[3]  = '{1'b0, 16'h0020, 16'h0008, 16'h000C, 1'b0};
    vecs[4]  = '{1'b0, 16'h0020, 16'h0008, 16'h000C, 1'b0};
    vecs[5]  = '{1'b1, 16'h0020, 16'h0020, 16'h0024, 1'b0};
    vecs[6]  = '{1'b1, 16'h000C, 16'h000C, 16'h0010, 1'b0};
    vecs[7]  = '{1'b1, 16'h0010, 16'h0010, 16'h0014, 1'b0};
    vecs[8]  = '{1'b1, 16'h0010, 16'h0010, 16'h0014, 1'b0};
    vecs[9]  = '{1'b1, 16'hFFFC, 16'hFFFC, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 16'h0006, 16'h0006, 16'h000A, 1'b1};
    vecs[11] = '{1'b1, 16'h0040, 16'h0040, 16'h0044, 1'b0};

    rst_n  = 1'b0;
    en     = 1'b1;
    pcNext = 16'h1234;
`ifdef PC_HISTORY_EN
    histSel = '0;
`endif
    #1;
    chk_all("rst_async", 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_hold", 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rst_release", 16'h1234);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en     = vecs[i].en;
      pcNext = vecs[i].nxt;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.pc", i), 32'(pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d.pcPlus4", i), 32'(pcPlus4), 32'(vecs[i].exp_p4));
      chk($sformatf("vec%0d.mis", i), 32'(misaligned), 32'(vecs[i].exp_mis));
    end

    // pcNext changing between edges must not reach pc.
    @(negedge clk);
    pcNext = 16'h5550;
    #2;
    chk("no_comb_path", 32'(pc), 32'h0040);

    // Async reset between edges, overriding en.
    rst_n = 1'b0;
    #1;
    chk_all("rst_midrun", 16'h0000);
    @(posedge clk);
    #1;
    chk_all("rst_mid_hold", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef PC_HISTORY_EN
    pcNext = 16'h0004;
    @(posedge clk);
    @(negedge clk);
    pcNext = 16'h0008;
    @(posedge clk);
    @(negedge clk);
    pcNext = 16'h000C;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    histSel = 2'd0; #1; chk("hist0", 32'(histPc), 32'h0008);
    histSel = 2'd1; #1; chk("hist1", 32'(histPc), 32'h0004);
    histSel = 2'd2; #1; chk("hist2", 32'(histPc), 32'h0000);
    histSel = 2'd3; #1; chk("hist3", 32'(histPc), 32'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
`endif

    // Randomized traffic against the reference model.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst_n  = ($urandom_range(0, 24) != 0);
      en     = ($urandom_range(0, 3) != 0);
      pcNext = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom & 32'hFFFC);
`ifdef PC_HISTORY_EN
      histSel = HAW'($urandom);
`endif
      #1;
      if (!rst_n) begin
        model_reset();
        chk("rand_async_rst", 32'(pc), 32'h0000);
      end
      @(posedge clk);
      if (rst_n && en) begin
        hq.push_front(m_pc);
        void'(hq.pop_back());
        m_pc = pcNext;
      end
      #1;
      chk_all($sformatf("rand%0d", c), m_pc);
`ifdef PC_HISTORY_EN
      chk($sformatf("rand%0d.hist", c), 32'(histPc), 32'(hq[histSel]));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
